// File: rtl/input_conditioner.sv
// Multi-channel pin front end: synchroniser chain, consecutive-sample debounce, and edge strobes.
// Define INPUT_CONDITIONER_STICKY_EN to add the req_ack/req_out sticky request latch.
module input_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
`ifdef INPUT_CONDITIONER_STICKY_EN
  input  logic [NUM_CH-1:0] req_ack,
  output logic [NUM_CH-1:0] req_out,
`endif
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_CH-1:0] sync_p [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_q;
  logic [CNT_W-1:0]  cnt_p1 [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] level_d;

  // Synchroniser: plain flop chain, nothing between stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync_q = sync_p[SYNC_STAGES-1];

  // Debounce: any sample agreeing with the current level restarts the run
  always_comb begin
    level_d = level_out;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_p1[i];
      if (sync_q[i] == level_out[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_p1[i] == CNT_MAX) begin
        level_d[i] = sync_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_p1[i] + CNT_ONE;
      end
    end
  end

  // Level and edge strobes register on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
      level_out <= '0;
      rise_out  <= '0;
      fall_out  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= cnt_d[i];
      level_out <= level_d;
      rise_out  <= level_d & ~level_out;
      fall_out  <= ~level_d & level_out;
    end
  end

`ifdef INPUT_CONDITIONER_STICKY_EN
  // Sticky request: set by a rise strobe, which outranks a same-cycle ack
  always_ff @(posedge clk) begin
    if (reset) req_out <= '0;
    else       req_out <= rise_out | (req_out & ~req_ack);
  end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a sliding-window reference model predicts every cycle.
module tb_input_conditioner;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] req_ack;
  logic [NUM_CH-1:0] level_out, rise_out, fall_out;
`ifdef INPUT_CONDITIONER_STICKY_EN
  logic [NUM_CH-1:0] req_out;
`endif

  input_conditioner #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
`ifdef INPUT_CONDITIONER_STICKY_EN
    .req_ack(req_ack),
    .req_out(req_out),
`endif
    .level_out(level_out),
    .rise_out(rise_out),
    .fall_out(fall_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] req;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: raw delayed SYNC edges; level flips once the last DEB
  // synced samples all disagree with it.
  logic [NUM_CH-1:0] m_hist [SYNC];
  logic [NUM_CH-1:0] m_win  [DEB];
  logic [NUM_CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_req = '0;

  always @(posedge clk) begin
    logic [NUM_CH-1:0] s, nl;
    bit all_diff;
    if (reset) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      for (int k = 0; k < DEB; k++)  m_win[k]  = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_req = '0;
    end else begin
      m_req = m_rise | (m_req & ~req_ack);
      s = m_hist[SYNC-1];
      for (int k = DEB-1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = s;
      for (int c = 0; c < NUM_CH; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (m_win[k][c] == m_level[c]) all_diff = 1'b0;
        nl[c] = all_diff ? ~m_level[c] : m_level[c];
      end
      m_rise  = nl & ~m_level;
      m_fall  = ~nl & m_level;
      m_level = nl;
      for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = raw_in;
    end
    exp_q.push_back('{level: m_level, rise: m_rise, fall: m_fall, req: m_req});
  end

  task automatic chk(input string nm, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: one prediction per clock edge, compared away from the edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("level_out", level_out, e.level);
      chk("rise_out", rise_out, e.rise);
      chk("fall_out", fall_out, e.fall);
`ifdef INPUT_CONDITIONER_STICKY_EN
      chk("req_out", req_out, e.req);
`endif
    end
  end

  int hold [NUM_CH];

  initial begin
    reset = 1'b1; raw_in = '0; req_ack = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    // Clean assert on ch0
    raw_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    // Short glitch on ch1
    raw_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    raw_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    // ch2 pulsed for 10 cycles while ch0 stays high
    raw_in[2] = 1'b1;
    repeat (10) @(negedge clk);
    raw_in[2] = 1'b0;
    repeat (12) @(negedge clk);
    // Reset in the middle of a ch3 debounce
    raw_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    // Ack ch1 request, then a fresh ch1 rise lined up with an ack
    req_ack[1] = 1'b1; @(negedge clk); req_ack[1] = 1'b0;
    raw_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    req_ack[1] = 1'b1; @(negedge clk); req_ack[1] = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized runs of varying length, occasional reset, random acks
    for (int c = 0; c < NUM_CH; c++) hold[c] = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          raw_in[c] = ~raw_in[c];
          hold[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, DEB))
                                                : int'($urandom_range(DEB, 3*DEB));
        end
      end
      req_ack = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)) & NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; req_ack = '0;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised multi-channel front end for asynchronous pushbutton and sensor inputs, such as the vehicle sensor, walk request and reprogram switch.
- Per channel, in order:
  - configurable-depth synchroniser chain
  - consecutive-sample debounce filter
  - registered rising-edge and falling-edge pulse generation
- Sits between the board pins and the traffic-light FSM and timer blocks. It supplies clean levels and single-cycle event strobes.

Parameters:
- NUM_CH, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: flip-flops in each synchroniser chain (≥2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a new synced value must persist before it is accepted (≥1).
- CNT_W, derived localparam, not overridable: $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  NUM_CH  asynchronous raw inputs, one bit per channel.
- level_out  output  NUM_CH  debounced stable level per channel.
- rise_out  output  NUM_CH  one-cycle pulse when level_out goes 0→1.
- fall_out  output  NUM_CH  one-cycle pulse when level_out goes 1→0.

Behaviour:
- Reset is synchronous and active-high: at a clk edge with reset=1, the following clear to 0:
  - all synchroniser stages
  - debounce counters
  - level_out, rise_out, fall_out
- Reset dominates every other event.
- Synchroniser:
  - Stage 1 samples raw_in each edge; stage i samples stage i-1.
  - sync_q is the last stage.
  - No logic is permitted between stages.
- Debounce, per channel, independent of all other channels:
  - If sync_q == level_out: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level_out ← sync_q and counter ← 0.
  - Else: counter ← counter+1.
  - One cycle of agreement with level_out restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never reach level_out.
- Latency: a clean raw change sampled at edge 0 appears on level_out after edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges counting edge 0.
- DEBOUNCE_CYCLES=1: the filter degenerates to a 1-cycle register; latency is SYNC_STAGES edges.
- Edge pulses:
  - rise_out[i] is asserted in exactly the cycle in which level_out[i] first reads 1 (registered on the same edge that sets it). fall_out behaves the same way for a transition to 0.
  - Each pulse lasts exactly 1 cycle.
  - rise_out[i] and fall_out[i] are never both high.
  - Minimum spacing between opposite pulses on one channel is DEBOUNCE_CYCLES cycles.
- Counter wrap: impossible by construction; the counter never exceeds DEBOUNCE_CYCLES-1.
- Reset mid-debounce discards the partial count.
- Reset with raw_in held high: after reset deasserts, level_out rises after the full latency and produces one rise_out pulse.
- Simultaneous transitions on several channels are handled independently in the same cycle.

Optional Feature:
- Macro: INPUT_CONDITIONER_STICKY_EN.
- When defined, two ports are added:
  - req_ack  input  NUM_CH
  - req_out  output  NUM_CH
- req_out[i] behaviour:
  - Set by rise_out[i].
  - Held until the cycle after req_ack[i]=1.
  - If rise_out[i] and req_ack[i] are high in the same cycle, set wins and req_out stays 1.
  - Reset clears req_out to 0.
- Purpose: the FSM can service a walk request that arrived mid-phase.
- When not defined: the ports and the latch logic are absent, and behaviour is exactly as above.

Test Plan:
- Setup for all scenarios unless stated: NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Clean assert: raw_in[0] 0→1 held → level_out[0]=1 after the 6th edge; rise_out[0]=1 for exactly that one cycle; fall_out=0.
- Glitch reject: raw_in[1] high for 3 cycles then low → level_out[1], rise_out[1] and fall_out[1] stay 0 throughout.
- Release and independence: ch0 held high, ch2 pulsed high for 10 cycles → ch2 shows one rise pulse and one fall pulse 10 cycles apart; ch0 level unchanged, no pulses.
- Reset mid-debounce: raw_in[3] rises, reset=1 for 1 cycle at edge 4 → all outputs 0; level_out[3] rises 6 edges after reset deasserts, with one rise pulse.
- Sticky (with INPUT_CONDITIONER_STICKY_EN): rise on ch1 → req_out[1]=1 held. req_ack[1] pulse → req_out[1]=0 next cycle. A new rise coincident with an ack → req_out[1] stays 1.
